counter_rate_ctrl: RTL
======================

# counter_rate_ctrl

Run/stop and single-step controller that produces the count-enable for the 4-stage synchronous down counter. It conditions two raw board pushbuttons (synchronise, debounce, edge-detect) and runs a small state machine. It emits a one-cycle `tick` either from a programmable prescaler while running, or once per step press while stopped. The counter advances only on cycles where `tick` is high.

## Interface
- `DIV_WIDTH`, default 26: prescaler counter width.
- `DIV_MAX`, default 49_999_999: prescaler terminal value; tick period is DIV_MAX+1 cycles (1 Hz at 50 MHz).
- `DB_CYCLES`, default 1_000_000: consecutive stable cycles required to accept a button level change (20 ms at 50 MHz); must be ≥2.
- `DB_WIDTH`, default 20: debounce counter width; 2^DB_WIDTH > DB_CYCLES.
- `clk`  in  1  single system clock, rising edge.
- `rst`  in  1  reset, asynchronous, active-low; one clock; reset is asynchronous and active-low.
- `btn_run`  in  1  raw asynchronous pushbutton, active-high; each accepted press toggles run/stop.
- `btn_step`  in  1  raw asynchronous pushbutton, active-high; each accepted press while stopped issues one tick.
- `tick`  out  1  registered count-enable, high for exactly one cycle per event.
- `running`  out  1  high while state is RUNNING.
- `state`  out  2  current FSM state: STOPPED=00, RUNNING=01, STEP=10; 11 is unused.

## Operation
- Reset (rst low): all flops cleared. State is STOPPED. `tick`=0, `running`=0, `state`=00, prescaler=0, debounced levels=0, debounce counters=0.
- Button conditioning, per button:
  - 2-flop synchroniser produces `s`.
  - Debounce counter increments on every edge where `s` ≠ debounced level `d`, and clears on every edge where they are equal.
  - On the edge where the counter equals DB_CYCLES-1 and `s` ≠ `d`, `d` takes `s` and the counter clears.
  - Press pulse = `d & ~d_prev` (combinational from registered `d`, `d_prev`). Release generates nothing.
- FSM:
  - STOPPED: run_press → RUNNING; step_press (with no run_press) → STEP.
  - RUNNING: run_press → STOPPED; step_press ignored.
  - STEP: unconditionally → STOPPED next edge; presses in this cycle are ignored.
  - Simultaneous run_press and step_press: run wins, step is dropped.
  - State 11 (illegal) → STOPPED.
- Prescaler:
  - In RUNNING: increments each cycle. At DIV_MAX it wraps to 0 and requests a tick.
  - In any other state: held at 0, so every entry to RUNNING starts a fresh full period.
- `tick` register loads (next_state==STEP) OR (state==RUNNING AND div_cnt==DIV_MAX).
  - A wrap on the same edge that leaves RUNNING still produces its tick.
- Arithmetic: unsigned, modulo 2^DIV_WIDTH. DIV_MAX must be < 2^DIV_WIDTH.

## Timing
- Button latency: the raw level is first sampled at edge 0. `s` changes at edge 1 and `d` changes at edge DB_CYCLES+1. The press pulse is high in the following cycle, and `state` changes at edge DB_CYCLES+2.
- Glitches shorter than DB_CYCLES cycles (post-synchroniser) never change `d`.
- Step tick: `tick`=1 in the same cycle `state`=STEP (registered together), for exactly one cycle.
- Run ticks: entering RUNNING at edge E produces the first `tick` high in the cycle after edge E+DIV_MAX+1. Ticks then repeat every DIV_MAX+1 cycles.
- Reset mid-operation: outputs go to reset values immediately (asynchronous). The first rising edge after rst deasserts behaves as edge 0 of normal operation.

## Structure
- Package `counter_ctrl_pkg`:
  - state encoding constants (ST_STOPPED, ST_RUNNING, ST_STEP);
  - default values for DIV_MAX and DB_CYCLES.
- Sub-module `button_conditioner` (synchroniser + debounce + rising-edge pulse), parameterised by DB_CYCLES and DB_WIDTH, instantiated twice.
- The top level contains only the FSM, the prescaler and the tick register.

## Test plan
All scenarios use DIV_MAX=9, DIV_WIDTH=4, DB_CYCLES=4, DB_WIDTH=3.
- Reset: hold rst low 3 cycles, then release → `tick`=0, `running`=0, `state`=00; no ticks for 50 cycles.
- Run: hold btn_run high 10 cycles → `state`=01 at edge 6 after first sample. `tick` pulses 10 cycles later, then every 10 cycles, each pulse exactly 1 cycle wide.
- Bounce: toggle btn_run with 1–3 cycle pulses for 20 cycles, then settle low → `state` stays 00, `tick` never asserts.
- Stop and step: stop from RUNNING with a second run press → prescaler cleared and `tick` quiet. Two clean step presses → exactly two single-cycle ticks, `state` sequence 00→10→00 each time.
- Simultaneous presses: raise btn_run and btn_step on the same cycle while STOPPED → `state` goes to 01; no STEP state, no immediate tick.
- Async reset mid-run: assert rst between ticks while RUNNING → all outputs 0 at once. After release, 30 idle cycles produce no tick, and `state` is 00.

Source files
------------

// File: rtl/counter_ctrl_pkg.sv
// counter_ctrl_pkg: state encoding and default timing constants for the rate controller.
package counter_ctrl_pkg;

    typedef enum logic [1:0] {
        ST_STOPPED = 2'b00,
        ST_RUNNING = 2'b01,
        ST_STEP    = 2'b10
    } state_e;

    localparam int unsigned DEF_DIV_MAX   = 49_999_999;
    localparam int unsigned DEF_DB_CYCLES = 1_000_000;

endpackage

// File: rtl/button_conditioner.sv
// button_conditioner: synchronises, debounces and edge-detects one raw pushbutton.
module button_conditioner #(
    parameter int unsigned DB_CYCLES = 1_000_000,
    parameter int          DB_WIDTH  = 20
) (
    input  logic clk,
    input  logic rst,
    input  logic btn_i,
    output logic press_o
);

    localparam logic [DB_WIDTH-1:0] LAST = DB_WIDTH'(DB_CYCLES - 1);

    logic [1:0]          sync_q;
    logic [DB_WIDTH-1:0] cnt_q, cnt_d;
    logic                d_q, d_d, dprev_q, diff;

    assign diff = sync_q[1] ^ d_q;

    always_comb begin
        cnt_d = (diff && cnt_q != LAST) ? cnt_q + DB_WIDTH'(1) : '0;
        d_d   = (diff && cnt_q == LAST) ? sync_q[1] : d_q;
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            sync_q  <= '0;
            cnt_q   <= '0;
            d_q     <= 1'b0;
            dprev_q <= 1'b0;
        end else begin
            sync_q  <= {sync_q[0], btn_i};
            cnt_q   <= cnt_d;
            d_q     <= d_d;
            dprev_q <= d_q;
        end
    end

    assign press_o = d_q & ~dprev_q;

endmodule

// File: rtl/counter_rate_ctrl.sv
// counter_rate_ctrl: run/stop/step FSM and prescaler producing the down-counter tick.
module counter_rate_ctrl
    import counter_ctrl_pkg::*;
#(
    parameter int          DIV_WIDTH = 26,
    parameter int unsigned DIV_MAX   = DEF_DIV_MAX,
    parameter int unsigned DB_CYCLES = DEF_DB_CYCLES,
    parameter int          DB_WIDTH  = 20
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       btn_run,
    input  logic       btn_step,
    output logic       tick,
    output logic       running,
    output logic [1:0] state
);

    localparam logic [DIV_WIDTH-1:0] DMAX = DIV_WIDTH'(DIV_MAX);

    state_e               state_q, state_d;
    logic [DIV_WIDTH-1:0] div_q, div_d;
    logic                 tick_q, tick_d, run_p, step_p, wrap;

    button_conditioner #(.DB_CYCLES(DB_CYCLES), .DB_WIDTH(DB_WIDTH)) u_run (
        .clk(clk), .rst(rst), .btn_i(btn_run), .press_o(run_p)
    );

    button_conditioner #(.DB_CYCLES(DB_CYCLES), .DB_WIDTH(DB_WIDTH)) u_step (
        .clk(clk), .rst(rst), .btn_i(btn_step), .press_o(step_p)
    );

    assign wrap = (state_q == ST_RUNNING) && (div_q == DMAX);

    // Run press takes priority over step; STEP and the unused encoding fall back to STOPPED.
    always_comb begin
        state_d = ST_STOPPED;
        state_d = (state_q == ST_STOPPED) ? (run_p ? ST_RUNNING : step_p ? ST_STEP : ST_STOPPED) :
                  (state_q == ST_RUNNING) ? (run_p ? ST_STOPPED : ST_RUNNING) : ST_STOPPED;
        div_d   = (state_q == ST_RUNNING && !wrap) ? div_q + DIV_WIDTH'(1) : '0;
        tick_d  = (state_d == ST_STEP) || wrap;
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= ST_STOPPED;
            div_q   <= '0;
            tick_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            div_q   <= div_d;
            tick_q  <= tick_d;
        end
    end

    assign tick    = tick_q;
    assign running = (state_q == ST_RUNNING);
    assign state   = state_q;

endmodule
